pipelined_addsub: RTL and testbench

//  Parametrised, pipelined two's-complement adder/subtractor for the arithmetic datapath.

---
 rtl/adder_pkg.sv | 19 +
 rtl/addsub_slice.sv | 29 ++
 rtl/pipelined_addsub.sv | 116 +++++++++++
 tb/tb_pipelined_addsub.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package : adder_pkg
// Brief   : Shared mode encoding and parameter check for the add/sub datapath.
// Rev     : 1.0
// ----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

   function automatic bit stages_divide_width(input int width, input int stages);
      return (stages > 0) && (width > 0) && ((width % stages) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : addsub_slice
// Brief   : Combinational carry-chain segment with carry-out and carry into MSB.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module addsub_slice
   import adder_pkg::*;
#(
   parameter int WIDTH = 4
)(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [WIDTH:0] w_full;

   assign w_full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   assign sum      = w_full[WIDTH-1:0];
   assign cout     = w_full[WIDTH];
   // Sum bit is a^b^carry, so the carry into the top bit falls out by XOR.
   assign c_msb_in = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : pipelined_addsub
// Brief   : Valid/ready pipelined two's-complement adder/subtractor, STAGES segments.
// Rev     : 1.0
// ----------------------------------------------------------------------------
module pipelined_addsub
   import adder_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int SEG = WIDTH / STAGES;

   if (!stages_divide_width(WIDTH, STAGES)) begin : g_bad_params
      $error("pipelined_addsub: WIDTH=%0d is not a multiple of STAGES=%0d", WIDTH, STAGES);
   end

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] w_rdy;
   logic [STAGES-1:0] w_vin;
   logic [WIDTH-1:0]  r_a   [STAGES];
   logic [WIDTH-1:0]  r_b   [STAGES];
   logic [WIDTH-1:0]  r_sum [STAGES];
   logic              r_c   [STAGES];
   logic              r_ovf [STAGES];
   logic [WIDTH-1:0]  w_ain [STAGES];
   logic [WIDTH-1:0]  w_bin [STAGES];
   logic [WIDTH-1:0]  w_sin [STAGES];
   logic              w_cin [STAGES];
   logic [SEG-1:0]    w_s   [STAGES];
   logic              w_co  [STAGES];
   logic              w_cmsb[STAGES];
   mode_e             w_mode;

   assign w_mode = mode_e'(in_sub);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Unrolled ready chain: a stage may load if any stage from here down is empty.
      assign w_rdy[k] = out_ready | ~(&r_v[STAGES-1:k]);

      if (k == 0) begin : g_entry
         assign w_vin[k] = in_valid;
         assign w_ain[k] = in_a;
         assign w_bin[k] = (w_mode == MODE_SUB) ? ~in_b : in_b;
         assign w_cin[k] = (w_mode == MODE_SUB) ? 1'b1 : in_cin;
         assign w_sin[k] = '0;
      end else begin : g_chain
         assign w_vin[k] = r_v[k-1];
         assign w_ain[k] = r_a[k-1];
         assign w_bin[k] = r_b[k-1];
         assign w_cin[k] = r_c[k-1];
         assign w_sin[k] = r_sum[k-1];
      end

      addsub_slice #(
         .WIDTH    (SEG)
      ) u_slice (
         .a        (w_ain[k][SEG-1:0]),
         .b        (w_bin[k][SEG-1:0]),
         .cin      (w_cin[k]),
         .sum      (w_s[k]),
         .cout     (w_co[k]),
         .c_msb_in (w_cmsb[k])
      );
   end

   // Operands shift down one segment per stage so the next segment is always
   // at the bottom; sum segments enter at the top and arrive aligned at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_sum[k] <= '0;
            r_c[k]   <= 1'b0;
            r_ovf[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_v[k]   <= w_vin[k];
               r_a[k]   <= w_ain[k] >> SEG;
               r_b[k]   <= w_bin[k] >> SEG;
               r_sum[k] <= WIDTH'({w_s[k], w_sin[k]} >> SEG);
               r_c[k]   <= w_co[k];
               r_ovf[k] <= w_co[k] ^ w_cmsb[k];
            end
         end
      end
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = r_v[STAGES-1];
   assign out_sum   = r_sum[STAGES-1];
   assign out_cout  = r_c[STAGES-1];
   assign out_ovf   = r_ovf[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_pipelined_addsub
// Brief   : Self-checking bench for pipelined_addsub (16/4 and 8/1 configurations).
// Rev     : 1.0
// ----------------------------------------------------------------------------
module tb_pipelined_addsub;

   localparam int W  = 16;
   localparam int S  = 4;
   localparam int W8 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          in_valid, in_ready, in_cin, in_sub;
   logic          out_valid, out_ready, out_cout, out_ovf;
   logic [W-1:0]  in_a, in_b, out_sum;
   logic          in_valid_8, in_ready_8, in_cin_8, in_sub_8;
   logic          out_valid_8, out_ready_8, out_cout_8, out_ovf_8;
   logic [W8-1:0] in_a_8, in_b_8, out_sum_8;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   res_t exp_q[$];

   pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf)
   );

   pipelined_addsub #(.WIDTH(W8), .STAGES(1)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid_8), .in_ready(in_ready_8), .in_a(in_a_8), .in_b(in_b_8),
      .in_cin(in_cin_8), .in_sub(in_sub_8),
      .out_valid(out_valid_8), .out_ready(out_ready_8), .out_sum(out_sum_8),
      .out_cout(out_cout_8), .out_ovf(out_ovf_8)
   );

   // Reference: modular arithmetic plus the textbook signed-overflow rule.
   function automatic res_t ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
      longint unsigned mask, aa, bb, full;
      logic sa, sb, ss;
      res_t r;
      mask   = (64'd1 << w) - 64'd1;
      aa     = 64'(a) & mask;
      bb     = sub ? (~64'(b)) & mask : 64'(b) & mask;
      full   = aa + bb + ((sub || cin) ? 64'd1 : 64'd0);
      r.sum  = 16'(full & mask);
      r.cout = full[w];
      sa     = aa[w-1];
      sb     = b[w-1];
      ss     = full[w-1];
      r.ovf  = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
      in_valid_8 = 1'b0; in_a_8 = '0; in_b_8 = '0; in_cin_8 = 1'b0; in_sub_8 = 1'b0; out_ready_8 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 16'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0)
         begin errors++; $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b expected all zero", out_valid, out_sum, out_cout, out_ovf); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (out_valid_8 !== 1'b0 || out_sum_8 !== 8'h0 || in_ready_8 !== 1'b1)
         begin errors++; $display("FAIL reset_dut8: got v=%b sum=%h rdy=%b expected 0 00 1", out_valid_8, out_sum_8, in_ready_8); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL post_reset_idle: got v=%b rdy=%b expected 0 1", out_valid, in_ready); end
   endtask

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] sum;
      logic        cout, ovf;
   } vec_t;

   task automatic test_directed();
      vec_t tv[7];
      int   lat;
      tv[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
      tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      tv[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tv[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tv[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
      tv[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid = 1'b1; in_a = tv[i].a; in_b = tv[i].b; in_cin = tv[i].cin; in_sub = tv[i].sub;
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_accept: in_ready got %b expected 1", i, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0;
         lat = 0;
         while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
         end
         checks++;
         if (lat != S - 1) begin errors++; $display("FAIL dir%0d_latency: got %0d edges expected %0d", i, lat, S - 1); end
         checks++;
         if (out_sum !== tv[i].sum || out_cout !== tv[i].cout || out_ovf !== tv[i].ovf)
            begin errors++; $display("FAIL dir%0d_result: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b", i, out_sum, out_cout, out_ovf, tv[i].sum, tv[i].cout, tv[i].ovf); end
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_drain: out_valid got %b expected 0", i, out_valid); end
      end
   endtask

   task automatic test_stall_stream();
      int   sent = 0, got = 0;
      bit   have = 0, held = 0, saw_low = 0;
      logic exp_rdy;
      logic [15:0] h_sum;
      logic h_c, h_o;
      res_t e;
      exp_q.delete();
      for (int cyc = 1; cyc <= 80 && got < 8; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 8);
         if (sent < 8) begin
            if (!have) begin
               in_a = 16'($urandom); in_b = 16'($urandom);
               in_cin = 1'($urandom); in_sub = 1'($urandom);
               have = 1;
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         exp_rdy = (exp_q.size() < S) || out_ready;
         checks++;
         if (in_ready !== exp_rdy) begin errors++; $display("FAIL stall_in_ready cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy); end
         if (in_ready === 1'b0) saw_low = 1;
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== h_sum || out_cout !== h_c || out_ovf !== h_o)
               begin errors++; $display("FAIL hold_stable cyc%0d: got v=%b sum=%h expected v=1 sum=%h", cyc, out_valid, out_sum, h_sum); end
         end
         held = out_valid && !out_ready;
         h_sum = out_sum; h_c = out_cout; h_o = out_ovf;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL stall_spurious cyc%0d: got out_valid=1 expected 0", cyc);
            end else begin
               e = exp_q.pop_front();
               if (out_sum !== e.sum || out_cout !== e.cout || out_ovf !== e.ovf)
                  begin errors++; $display("FAIL stall_result%0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b", got, out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf); end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_op(W, in_a, in_b, in_cin, in_sub));
            sent++;
            have = 0;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (got != 8) begin errors++; $display("FAIL stall_count: got %0d results expected 8", got); end
      checks++;
      if (!saw_low) begin errors++; $display("FAIL stall_backpressure: in_ready low seen=%0d expected 1", saw_low); end
   endtask

   task automatic test_reset_midstream();
      int lat;
      bit stale = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'b0; in_sub = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_precond: out_valid got %b expected 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_sum !== 16'h0 || in_ready !== 1'b1)
         begin errors++; $display("FAIL midrst_async: got v=%b sum=%h rdy=%b expected 0 0000 1", out_valid, out_sum, in_ready); end
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stale = 1;
      end
      checks++;
      if (stale) begin errors++; $display("FAIL midrst_stale: got out_valid=1 after reset expected 0"); end
      in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0001; in_cin = 1'b0; in_sub = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != S - 1 || out_sum !== 16'h0002)
         begin errors++; $display("FAIL midrst_next_op: got sum=%h lat=%0d expected sum=0002 lat=%0d", out_sum, lat, S - 1); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      res_t q8[$];
      res_t e;
      out_ready_8 = 1'b1;
      in_valid_8 = 1'b1; in_a_8 = 8'h80; in_b_8 = 8'h80; in_cin_8 = 1'b0; in_sub_8 = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready_8 !== 1'b1) begin errors++; $display("FAIL s1_accept: in_ready got %b expected 1", in_ready_8); end
      @(posedge clk); #1;
      in_valid_8 = 1'b0;
      checks++;
      if (out_valid_8 !== 1'b1 || out_sum_8 !== 8'h00 || out_cout_8 !== 1'b1 || out_ovf_8 !== 1'b1)
         begin errors++; $display("FAIL s1_8080: got v=%b sum=%h c=%b o=%b expected 1 00 1 1", out_valid_8, out_sum_8, out_cout_8, out_ovf_8); end
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         if (cyc < 12) begin
            in_valid_8 = 1'b1; in_a_8 = 8'($urandom); in_b_8 = 8'($urandom);
            in_cin_8 = 1'($urandom); in_sub_8 = 1'($urandom);
         end else begin
            in_valid_8 = 1'b0;
         end
         @(negedge clk);
         checks++;
         if (out_valid_8 !== ((cyc >= 1 && cyc <= 12) ? 1'b1 : 1'b0))
            begin errors++; $display("FAIL s1_bubble cyc%0d: out_valid got %b", cyc, out_valid_8); end
         if (out_valid_8 === 1'b1 && q8.size() > 0) begin
            e = q8.pop_front();
            checks++;
            if (out_sum_8 !== e.sum[7:0] || out_cout_8 !== e.cout || out_ovf_8 !== e.ovf)
               begin errors++; $display("FAIL s1_result cyc%0d: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b", cyc, out_sum_8, out_cout_8, out_ovf_8, e.sum[7:0], e.cout, e.ovf); end
         end
         if (in_valid_8) begin
            checks++;
            if (in_ready_8 !== 1'b1) begin errors++; $display("FAIL s1_in_ready cyc%0d: got %b expected 1", cyc, in_ready_8); end
            q8.push_back(ref_op(W8, {8'h00, in_a_8}, {8'h00, in_b_8}, in_cin_8, in_sub_8));
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_stall_stream();
      test_reset_midstream();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
